kfps2kb_keycode_fifo: RTL and testbench

- Stage directly downstream of the PS/2 bit-level receiver.
- Captures each validated scancode byte, signalled by a one-cycle received strobe, into a small circular FIFO.
- Presents the head byte and a level IRQ to the XT-side keyboard port logic, which pops with a one-cycle clear pulse.
- Logs framing/parity/timeout errors from the receiver. Optionally injects a 0xFF overrun marker, matching XT keyboard behaviour.

---
 rtl/kfps2kb_pkg.sv | 17 +
 rtl/kfps2kb_fifo_core.sv | 94 +++++++++
 rtl/kfps2kb_keycode_fifo.sv | 106 ++++++++++
 tb/tb_kfps2kb_keycode_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/kfps2kb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kfps2kb_pkg
// Brief    : Shared types and constants for the PS/2-to-XT keyboard path.
// Revision : 1.0 - initial release
// ============================================================================
package kfps2kb_pkg;

  localparam int KEYCODE_WIDTH = 8;

  typedef logic [KEYCODE_WIDTH-1:0] keycode_t;

  // Byte an XT keyboard sends when its internal buffer overruns.
  localparam keycode_t OVERRUN_CODE = 8'hFF;

endpackage : kfps2kb_pkg
`default_nettype wire

// File: rtl/kfps2kb_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : kfps2kb_fifo_core
// Brief    : Circular byte buffer with push/pop/flush, level and full/empty,
//            plus an in-place overwrite of the newest stored entry.
// Revision : 1.0 - initial release
// ============================================================================
module kfps2kb_fifo_core
  import kfps2kb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,          // async, active low
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  overwrite_last, // rewrite entry at wr_ptr-1
  input  keycode_t              wdata,
  output keycode_t              rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int                  DEPTH     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   C_LVL_ONE = 1;

  keycode_t                mem_q [DEPTH];
  keycode_t                mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q,  level_d;
  logic                    w_do_push;
  logic                    w_do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == C_DEPTH);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state: pop ignored when empty; push accepted when not full or when a
  // pop frees a slot in the same cycle. Flush overrides everything.
  always_comb begin
    w_do_pop  = pop && !empty;
    w_do_push = push && (!full || w_do_pop);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
      end else if (overwrite_last && !empty) begin
        mem_d[wr_ptr_q - C_PTR_ONE] = wdata;
      end
      if (w_do_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      if (w_do_push && !w_do_pop) begin
        level_d = level_q + C_LVL_ONE;
      end else if (w_do_pop && !w_do_push) begin
        level_d = level_q - C_LVL_ONE;
      end
    end
  end

  // Pointer/level state, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are meaningless while level is zero, so no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule : kfps2kb_fifo_core
`default_nettype wire

// File: rtl/kfps2kb_keycode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kfps2kb_keycode_fifo
// Brief    : Scancode FIFO between the PS/2 receiver and the XT port. Qualifies
//            receiver strobes, injects overrun markers, tracks overflow and a
//            saturating error count, and drives the level IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module kfps2kb_keycode_fifo
  import kfps2kb_pkg::*;
#(
  parameter int DEPTH_LOG2   = 3,
  parameter int ERROR_MARKER = 1
) (
  input  logic                  clock,
  input  logic                  reset,           // async, active low
  input  keycode_t              keycode_in,
  input  logic                  received_flag,
  input  logic                  error_flag,
  input  logic                  keyboard_enable,
  input  logic                  clear_keycode,
  input  logic                  flush,
  output keycode_t              keycode,
  output logic                  irq,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [7:0]            error_count
);

  localparam logic C_MARKER = (ERROR_MARKER != 0);

  logic                 w_err_push;
  logic                 w_rcv_push;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_overwrite;
  keycode_t             w_wdata;
  keycode_t             w_rdata;
  logic [DEPTH_LOG2:0]  w_level;
  logic                 w_full;
  logic                 w_empty;
  logic                 overflow_q, overflow_d;
  logic [7:0]           error_count_q, error_count_d;

  // Error strobe beats a simultaneous received strobe; with markers disabled
  // such a cycle pushes nothing.
  assign w_err_push  = keyboard_enable && error_flag && C_MARKER;
  assign w_rcv_push  = keyboard_enable && received_flag && !error_flag;
  assign w_push      = w_err_push || w_rcv_push;
  // A full FIFO is never empty, so a concurrent clear always frees a slot.
  assign w_drop      = w_push && w_full && !clear_keycode;
  assign w_overwrite = w_drop && C_MARKER;
  assign w_wdata     = (w_err_push || w_overwrite) ? OVERRUN_CODE : keycode_in;

  kfps2kb_fifo_core #(
    .DEPTH_LOG2     (DEPTH_LOG2)
  ) u_core (
    .clock          (clock),
    .reset          (reset),
    .push           (w_push),
    .pop            (clear_keycode),
    .flush          (flush),
    .overwrite_last (w_overwrite),
    .wdata          (w_wdata),
    .rdata          (w_rdata),
    .level          (w_level),
    .full           (w_full),
    .empty          (w_empty)
  );

  // Sticky overflow and saturating error counter next-state.
  always_comb begin
    overflow_d    = overflow_q;
    error_count_d = error_count_q;
    if (flush) begin
      overflow_d    = 1'b0;
      error_count_d = '0;
    end else begin
      if (w_drop) begin
        overflow_d = 1'b1;
      end
      if (keyboard_enable && error_flag && (error_count_q != 8'hFF)) begin
        error_count_d = error_count_q + 8'd1;
      end
    end
  end

  // Status registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q    <= 1'b0;
      error_count_q <= '0;
    end else begin
      overflow_q    <= overflow_d;
      error_count_q <= error_count_d;
    end
  end

  assign irq         = !w_empty;
  assign keycode     = w_empty ? '0 : w_rdata;
  assign level       = w_level;
  assign overflow    = overflow_q;
  assign error_count = error_count_q;

endmodule : kfps2kb_keycode_fifo
`default_nettype wire

// File: tb/tb_kfps2kb_keycode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_kfps2kb_keycode_fifo
// Brief    : Self-checking bench; two instances (marker on / marker off) share
//            stimulus and are compared against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kfps2kb_keycode_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] keycode_in;
  logic       received_flag, error_flag, keyboard_enable, clear_keycode, flush;

  logic [7:0] key_m, key_n, ec_m, ec_n;
  logic       irq_m, irq_n, ovf_m, ovf_n;
  logic [3:0] lvl_m, lvl_n;

  always #5 clock = ~clock;

  kfps2kb_keycode_fifo #(.DEPTH_LOG2(3), .ERROR_MARKER(1)) u_dut_m (
    .clock(clock), .reset(reset), .keycode_in(keycode_in),
    .received_flag(received_flag), .error_flag(error_flag),
    .keyboard_enable(keyboard_enable), .clear_keycode(clear_keycode),
    .flush(flush), .keycode(key_m), .irq(irq_m), .level(lvl_m),
    .overflow(ovf_m), .error_count(ec_m));

  kfps2kb_keycode_fifo #(.DEPTH_LOG2(3), .ERROR_MARKER(0)) u_dut_n (
    .clock(clock), .reset(reset), .keycode_in(keycode_in),
    .received_flag(received_flag), .error_flag(error_flag),
    .keyboard_enable(keyboard_enable), .clear_keycode(clear_keycode),
    .flush(flush), .keycode(key_n), .irq(irq_n), .level(lvl_n),
    .overflow(ovf_n), .error_count(ec_n));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: index 1 = marker instance, index 0 = log-only instance.
  typedef logic [7:0] bq_t [$];
  bq_t mq [2];
  bit  movf [2];
  int  mcnt [2];

  typedef struct {
    bit         rcv, err, en, clr, fl;
    logic [7:0] din;
    logic [3:0] lvl;
    logic [7:0] key;
    bit         irq;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] head(input int m);
    return (mq[m].size() != 0) ? mq[m][0] : 8'h00;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      movf[m] = 1'b0;
      mcnt[m] = 0;
    end
  endtask

  task automatic model_edge(input bit rcv, err, en, clr, fl, input logic [7:0] din);
    for (int m = 0; m < 2; m++) begin
      bit push, pop;
      logic [7:0] data;
      push = en && ((err && m == 1) || (rcv && !err));
      data = (err && m == 1) ? 8'hFF : din;
      if (fl) begin
        mq[m].delete();
        movf[m] = 1'b0;
        mcnt[m] = 0;
      end else begin
        pop = clr && (mq[m].size() != 0);
        if (en && err && mcnt[m] < 255) mcnt[m]++;
        if (pop) void'(mq[m].pop_front());
        if (push) begin
          if (mq[m].size() < 8) mq[m].push_back(data);
          else begin
            movf[m] = 1'b1;
            if (m == 1) mq[m][mq[m].size()-1] = 8'hFF;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("level_m", lvl_m, mq[1].size());
    chk("level_n", lvl_n, mq[0].size());
    chk("irq_m",   irq_m, mq[1].size() != 0);
    chk("irq_n",   irq_n, mq[0].size() != 0);
    chk("key_m",   key_m, head(1));
    chk("key_n",   key_n, head(0));
    chk("ovf_m",   ovf_m, movf[1]);
    chk("ovf_n",   ovf_n, movf[0]);
    chk("errc_m",  ec_m,  mcnt[1]);
    chk("errc_n",  ec_n,  mcnt[0]);
  endtask

  // One clock: drive inputs, check popped bytes against the scoreboard head,
  // advance the reference at the edge, then compare all outputs.
  task automatic cycle(input bit rcv, err, en, clr, fl, input logic [7:0] din);
    received_flag   = rcv;
    error_flag      = err;
    keyboard_enable = en;
    clear_keycode   = clr;
    flush           = fl;
    keycode_in      = din;
    if (clr && mq[1].size() != 0) chk("pop_m", key_m, mq[1][0]);
    if (clr && mq[0].size() != 0) chk("pop_n", key_n, mq[0][0]);
    @(posedge clock);
    model_edge(rcv, err, en, clr, fl, din);
    #1;
    received_flag = 1'b0;
    error_flag    = 1'b0;
    clear_keycode = 1'b0;
    flush         = 1'b0;
    compare_all();
  endtask

  task automatic push_b(input logic [7:0] b);
    cycle(1, 0, 1, 0, 0, b);
  endtask

  task automatic pop_b();
    cycle(0, 0, 1, 1, 0, 8'h00);
  endtask

  initial begin
    // rcv err en clr fl din   lvl key   irq
    tbl[0] = '{1, 0, 1, 0, 0, 8'h1C, 4'd1, 8'h1C, 1};
    tbl[1] = '{0, 0, 1, 1, 0, 8'h00, 4'd0, 8'h00, 0};
    tbl[2] = '{0, 1, 1, 0, 0, 8'h00, 4'd1, 8'hFF, 1};
    tbl[3] = '{0, 0, 1, 1, 0, 8'h00, 4'd0, 8'h00, 0};
    tbl[4] = '{1, 0, 0, 0, 0, 8'h2A, 4'd0, 8'h00, 0};
    tbl[5] = '{0, 0, 1, 1, 0, 8'h00, 4'd0, 8'h00, 0};
    tbl[6] = '{1, 1, 1, 0, 0, 8'h33, 4'd1, 8'hFF, 1};
    tbl[7] = '{1, 0, 1, 0, 1, 8'h44, 4'd0, 8'h00, 0};

    reset = 1'b0; keycode_in = 8'h00; received_flag = 1'b0; error_flag = 1'b0;
    keyboard_enable = 1'b1; clear_keycode = 1'b0; flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_level", lvl_m, 0);
    chk("rst_irq",   irq_m, 0);
    chk("rst_key",   key_m, 0);
    chk("rst_ovf",   ovf_m, 0);
    chk("rst_errc",  ec_m,  0);
    reset = 1'b1;

    // Table-driven basics on the marker instance.
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].rcv, tbl[i].err, tbl[i].en, tbl[i].clr, tbl[i].fl, tbl[i].din);
      chk($sformatf("tbl%0d_level", i), lvl_m, tbl[i].lvl);
      chk($sformatf("tbl%0d_key", i),   key_m, tbl[i].key);
      chk($sformatf("tbl%0d_irq", i),   irq_m, tbl[i].irq);
    end

    // Fill, then overflow with one more byte; drain in order.
    cycle(0, 0, 1, 0, 1, 8'h00);
    for (int i = 1; i <= 9; i++) push_b(8'(i));
    chk("ovfl_flag_m", ovf_m, 1);
    chk("ovfl_flag_n", ovf_n, 1);
    chk("ovfl_level",  lvl_m, 8);
    for (int i = 0; i < 7; i++) pop_b();
    chk("ovfl_last_m", key_m, 8'hFF);
    chk("ovfl_last_n", key_n, 8'h08);
    pop_b();

    // Full FIFO: push and pop in the same cycle never overflows.
    cycle(0, 0, 1, 0, 1, 8'h00);
    for (int i = 1; i <= 8; i++) push_b(8'(8'h10 + i));
    cycle(1, 0, 1, 1, 0, 8'h55);
    chk("fullpp_ovf",   ovf_m, 0);
    chk("fullpp_level", lvl_m, 8);
    for (int i = 0; i < 7; i++) pop_b();
    chk("fullpp_last", key_m, 8'h55);
    pop_b();

    // Error counter saturation.
    cycle(0, 0, 1, 0, 1, 8'h00);
    for (int i = 0; i < 300; i++) cycle(0, 1, 1, 0, 0, 8'h00);
    chk("errsat_n",   ec_n,  8'hFF);
    chk("errsat_lvl", lvl_n, 0);
    cycle(0, 0, 1, 0, 1, 8'h00);
    cycle(1, 1, 1, 0, 0, 8'h12);
    chk("both_errc", ec_n,  1);
    chk("both_lvl",  lvl_n, 0);

    // Disabled strobes, empty pop, wrap-around ordering.
    cycle(0, 0, 1, 0, 1, 8'h00);
    push_b(8'hA1);
    cycle(1, 0, 0, 0, 0, 8'hB1);
    cycle(0, 1, 0, 0, 0, 8'hB2);
    cycle(1, 0, 0, 0, 0, 8'hB3);
    chk("dis_level", lvl_m, 1);
    chk("dis_errc",  ec_m,  0);
    pop_b();
    pop_b();
    chk("empty_pop_lvl", lvl_m, 0);
    for (int i = 0; i < 12; i++) begin
      push_b(8'(8'h60 + i));
      pop_b();
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) push_b(8'(8'h70 + i));
    chk("pre_rst_lvl", lvl_m, 5);
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("arst_level", lvl_m, 0);
    chk("arst_irq",   irq_m, 0);
    chk("arst_key",   key_m, 0);
    chk("arst_lvl_n", lvl_n, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    push_b(8'h9C);
    pop_b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_kfps2kb_keycode_fifo
`default_nettype wire
